// File: rtl/wb_stage_pipe.sv
// Writeback stage with a small retire FIFO.
//
// Retire requests arrive on a valid/ready handshake. Each request carries NSRC
// candidate write sources, and the lowest-index enabled source wins. The
// selected write is buffered in a DEPTH-entry FIFO. The stage then issues one
// registered register-file write per retired instruction.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid / in_ready  retire request handshake
//   in_wen [NSRC]        per-source write enable
//   in_rd  [AW]          destination register
//   in_wdata [NSRC*XLEN] per-source data, source i at [i*XLEN +: XLEN]
//   wb_hold              regfile side cannot take a write this cycle
//   flush                drop every buffered request
//   out_valid            one-cycle retire pulse
//   out_wen/out_waddr/out_wdata  registered regfile write
//   commit_cnt           retired-instruction count (wraps)
//   fifo_cnt             current FIFO occupancy

module wb_stage_pipe #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NSRC  = 2,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NSRC-1:0]          in_wen,
  input  logic [AW-1:0]            in_rd,
  input  logic [NSRC*XLEN-1:0]     in_wdata,
  input  logic                     wb_hold,
  input  logic                     flush,
  output logic                     out_valid,
  output logic                     out_wen,
  output logic [AW-1:0]            out_waddr,
  output logic [XLEN-1:0]          out_wdata,
  output logic [63:0]              commit_cnt,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  // FIFO storage; no reset needed because the pointers and count gate every read.
  logic [DEPTH-1:0] mem_wen_q;
  logic [AW-1:0]    mem_addr_q [DEPTH];
  logic [XLEN-1:0]  mem_data_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [63:0]      commit_q, commit_d;

  logic             out_valid_q, out_valid_d;
  logic             out_wen_q, out_wen_d;
  logic [AW-1:0]    out_waddr_q, out_waddr_d;
  logic [XLEN-1:0]  out_wdata_q, out_wdata_d;

  logic             push, pop;
  logic             sel_found;
  logic [XLEN-1:0]  sel_data;
  logic             new_wen;
  logic [XLEN-1:0]  new_data;

  // Fixed priority: the lowest enabled source index wins.
  always_comb begin
    sel_found = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (!sel_found && in_wen[i]) begin
        sel_found = 1'b1;
        sel_data  = in_wdata[i*XLEN +: XLEN];
      end
    end
  end

  // Writes to x0, or requests with no source enabled, still retire but carry no data.
  assign new_wen  = sel_found && (in_rd != '0);
  assign new_data = new_wen ? sel_data : '0;

  assign in_ready = !rst && !flush && (cnt_q < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (cnt_q != '0) && !wb_hold && !flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    commit_d    = commit_q;
    out_valid_d = 1'b0;
    out_wen_d   = 1'b0;
    out_waddr_d = out_waddr_q;
    out_wdata_d = '0;

    if (flush) begin
      // Flush wins over push and pop; commit_cnt and the last address are kept.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d    = rd_ptr_q + PW'(1);
        commit_d    = commit_q + 64'd1;
        out_valid_d = 1'b1;
        out_wen_d   = mem_wen_q[rd_ptr_q];
        out_waddr_d = mem_addr_q[rd_ptr_q];
        out_wdata_d = mem_data_q[rd_ptr_q];
      end
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      commit_q    <= '0;
      out_valid_q <= 1'b0;
      out_wen_q   <= 1'b0;
      out_waddr_q <= '0;
      out_wdata_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      commit_q    <= commit_d;
      out_valid_q <= out_valid_d;
      out_wen_q   <= out_wen_d;
      out_waddr_q <= out_waddr_d;
      out_wdata_q <= out_wdata_d;
    end
  end

  // push is already gated off by in_ready during reset and flush.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_wen_q[wr_ptr_q]  <= new_wen;
      mem_addr_q[wr_ptr_q] <= in_rd;
      mem_data_q[wr_ptr_q] <= new_data;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_wen    = out_wen_q;
  assign out_waddr  = out_waddr_q;
  assign out_wdata  = out_wdata_q;
  assign commit_cnt = commit_q;
  assign fifo_cnt   = cnt_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Self-checking bench for wb_stage_pipe: a queue-based reference model is
// compared with the DUT on every falling edge. Directed literal checks pin the
// model, followed by a randomized phase.

module tb_wb_stage_pipe;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NSRC  = 2;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned AW    = 5;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [NSRC-1:0]        in_wen;
  logic [AW-1:0]          in_rd;
  logic [NSRC*XLEN-1:0]   in_wdata;
  logic                   wb_hold;
  logic                   flush;
  logic                   out_valid;
  logic                   out_wen;
  logic [AW-1:0]          out_waddr;
  logic [XLEN-1:0]        out_wdata;
  logic [63:0]            commit_cnt;
  logic [$clog2(DEPTH):0] fifo_cnt;

  wb_stage_pipe #(
    .XLEN (XLEN),
    .NSRC (NSRC),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_wen    (in_wen),
    .in_rd     (in_rd),
    .in_wdata  (in_wdata),
    .wb_hold   (wb_hold),
    .flush     (flush),
    .out_valid (out_valid),
    .out_wen   (out_wen),
    .out_waddr (out_waddr),
    .out_wdata (out_wdata),
    .commit_cnt(commit_cnt),
    .fifo_cnt  (fifo_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a queue of pending writes plus the visible output values.
  typedef struct {
    logic            wen;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t          mq[$];
  logic            m_valid;
  logic            m_wen;
  logic [AW-1:0]   m_waddr;
  logic [XLEN-1:0] m_wdata;
  logic [63:0]     m_commit;
  bit              started = 0;

  always @(posedge clk) begin
    entry_t e;
    entry_t h;
    bit     can_push;
    started <= 1;
    if (rst) begin
      mq.delete();
      m_valid  <= 0;
      m_wen    <= 0;
      m_waddr  <= '0;
      m_wdata  <= '0;
      m_commit <= '0;
    end else if (flush) begin
      mq.delete();
      m_valid <= 0;
      m_wen   <= 0;
      m_wdata <= '0;
    end else begin
      can_push = in_valid && (mq.size() < DEPTH);
      e.wen  = 0;
      e.addr = in_rd;
      e.data = '0;
      for (int i = 0; i < int'(NSRC); i++) begin
        if (in_wen[i]) begin
          e.wen  = (in_rd != 0);
          e.data = (in_rd != 0) ? in_wdata[i*XLEN +: XLEN] : '0;
          break;
        end
      end
      if (mq.size() > 0 && !wb_hold) begin
        h = mq.pop_front();
        m_valid  <= 1;
        m_wen    <= h.wen;
        m_waddr  <= h.addr;
        m_wdata  <= h.data;
        m_commit <= m_commit + 64'd1;
      end else begin
        m_valid <= 0;
        m_wen   <= 0;
        m_wdata <= '0;
      end
      if (can_push) mq.push_back(e);
    end
  end

  // Compare process.
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready, !rst && !flush && (mq.size() < DEPTH));
      chk("out_valid", out_valid, m_valid);
      chk("out_wen", out_wen, m_wen);
      chk("out_waddr", out_waddr, m_waddr);
      chk("out_wdata", out_wdata, m_wdata);
      chk("commit_cnt", commit_cnt, m_commit);
      chk("fifo_cnt", fifo_cnt, mq.size());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] wen, input logic [AW-1:0] rd,
                       input logic [63:0] d0, input logic [63:0] d1);
    in_valid = v;
    in_wen   = wen;
    in_rd    = rd;
    in_wdata = {d1, d0};
  endtask

  initial begin
    rst = 1; flush = 0; wb_hold = 0;
    drive(0, 2'b00, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_commit", commit_cnt, 0);
    chk("rst_out_valid", out_valid, 0);
    tick();
    rst = 0;

    // Test 1: both sources enabled, source 0 wins.
    drive(1, 2'b11, 5, 64'h11, 64'h22);
    tick();
    drive(0, 2'b00, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("t1_valid", out_valid, 1);
    chk("t1_wen", out_wen, 1);
    chk("t1_waddr", out_waddr, 5);
    chk("t1_wdata", out_wdata, 64'h11);
    chk("t1_commit", commit_cnt, 1);

    // Test 2: rd=0 and then no source enabled still retire, without a write.
    tick();
    drive(1, 2'b10, 0, 0, 64'hAB);
    tick();
    drive(0, 2'b00, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("t2a_valid", out_valid, 1);
    chk("t2a_wen", out_wen, 0);
    chk("t2a_wdata", out_wdata, 0);
    chk("t2a_commit", commit_cnt, 2);
    tick();
    drive(1, 2'b00, 7, 64'h55, 64'h66);
    tick();
    drive(0, 2'b00, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("t2b_wen", out_wen, 0);
    chk("t2b_waddr", out_waddr, 7);
    chk("t2b_commit", commit_cnt, 3);

    // Test 3: fill under hold, then drain in order.
    tick();
    wb_hold = 1;
    drive(1, 2'b01, 1, 64'hA1, 0);
    tick();
    drive(1, 2'b01, 2, 64'hA2, 0);
    tick();
    drive(1, 2'b01, 3, 64'hA3, 0);
    @(negedge clk);
    chk("t3_full_cnt", fifo_cnt, 2);
    chk("t3_full_ready", in_ready, 0);
    tick();
    wb_hold = 0;
    tick();
    tick();
    drive(0, 2'b00, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("t3_commit", commit_cnt, 6);
    chk("t3_waddr", out_waddr, 3);
    chk("t3_wdata", out_wdata, 64'hA3);

    // Test 4: ten back-to-back requests.
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, 2'b10, AW'(i + 10), 0, 64'(i * 3 + 1));
      tick();
    end
    drive(0, 2'b00, 0, 0, 0);
    repeat (3) tick();
    @(negedge clk);
    chk("t4_commit", commit_cnt, 16);
    chk("t4_cnt", fifo_cnt, 0);

    // Test 5: flush with two buffered entries; a push in the flush cycle is refused.
    tick();
    wb_hold = 1;
    drive(1, 2'b01, 4, 64'hF1, 0);
    tick();
    drive(1, 2'b01, 6, 64'hF2, 0);
    tick();
    flush = 1;
    drive(1, 2'b01, 8, 64'hF3, 0);
    @(negedge clk);
    chk("t5_flush_ready", in_ready, 0);
    tick();
    flush = 0;
    wb_hold = 0;
    drive(0, 2'b00, 0, 0, 0);
    @(negedge clk);
    chk("t5_cnt", fifo_cnt, 0);
    repeat (3) tick();
    @(negedge clk);
    chk("t5_valid", out_valid, 0);
    chk("t5_commit", commit_cnt, 16);

    // Test 6: reset with two entries buffered.
    tick();
    wb_hold = 1;
    drive(1, 2'b01, 9, 64'hC1, 0);
    tick();
    drive(1, 2'b01, 10, 64'hC2, 0);
    tick();
    drive(0, 2'b00, 0, 0, 0);
    wb_hold = 0;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_commit", commit_cnt, 0);
    chk("t6_cnt", fifo_cnt, 0);
    chk("t6_valid", out_valid, 0);
    chk("t6_waddr", out_waddr, 0);
    tick();
    rst = 0;
    @(negedge clk);
    chk("t6_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    chk("t6_no_write", out_valid, 0);

    // Randomized phase.
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst     = ($urandom_range(0, 299) == 0);
      flush   = ($urandom_range(0, 24) == 0);
      wb_hold = ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 3) != 0, 2'($urandom),
            ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom});
    end
    tick();
    rst = 0; flush = 0; wb_hold = 0;
    drive(0, 2'b00, 0, 0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
Parametrised writeback stage that replaces the single-cycle combinational write-back mux. It accepts retire requests from the EX/MEM side through a valid/ready handshake. Each request carries NSRC candidate write sources; the stage selects one by fixed priority and buffers the result in a DEPTH-entry FIFO. It then drives one registered register-file write per retired instruction, stalls on a regfile-side hold, supports pipeline flush, and counts retired instructions.

Parameters:
XLEN, 64, data width of a register write
NSRC, 2, number of write sources per request; index 0 has highest priority
DEPTH, 2, FIFO entries; power of two, >= 2
AW, 5, register address width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  retire request valid
in_ready  out  1  stage can accept a request this cycle
in_wen  in  NSRC  per-source write enable
in_rd  in  AW  destination register
in_wdata  in  NSRC*XLEN  per-source data; source i occupies bits [i*XLEN +: XLEN]
wb_hold  in  1  regfile side cannot take a write this cycle
flush  in  1  discard all buffered requests
out_valid  out  1  one-cycle retire pulse
out_wen  out  1  regfile write enable
out_waddr  out  AW  regfile write address
out_wdata  out  XLEN  regfile write data
commit_cnt  out  64  retired-instruction count
fifo_cnt  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous and active-high.
- Reset values:
  - out_valid=0, out_wen=0, out_waddr=0, out_wdata=0.
  - commit_cnt=0, fifo_cnt=0, FIFO pointers=0.
  - in_ready=0 while rst is high.
- Handshake:
  - in_ready = !rst && !flush && (fifo_cnt < DEPTH). It depends only on state and flush, never on in_valid.
  - A push occurs when in_valid && in_ready at a rising edge.
- Source select (at push):
  - sel = lowest i with in_wen[i]=1.
  - Stored entry: wen = any(in_wen) && (in_rd != 0); addr = in_rd; data = in_wdata[sel].
  - If no source is enabled, or rd==0, store wen=0 and data=0. The entry still retires.
- Pop:
  - A pop occurs when fifo_cnt>0 && !wb_hold && !flush.
  - On the edge that pops the head, out_* register the head contents and out_valid=1.
  - Otherwise out_valid=0, out_wen=0, out_wdata=0, and out_waddr holds its last value.
- Latency:
  - A request pushed at edge k pops at edge k+1 at the earliest, so out_valid is high in cycle k+1..k+2.
  - Sustained throughput is 1 request/cycle with no hold.
- Simultaneous push and pop: fifo_cnt is unchanged, and both pointers advance modulo DEPTH (wrap-around).
- Full: in_ready=0, so no push. A pop in that cycle frees the slot for the next cycle, not the same one.
- Empty with wb_hold high: no effect.
- wb_hold high with FIFO non-empty:
  - Head is held and out_valid=0.
  - Pushes continue until full.
- Flush:
  - Takes priority over push and pop.
  - Next edge: pointers=0, fifo_cnt=0, out_valid=0, out_wen=0.
  - commit_cnt is unchanged.
- commit_cnt increments by 1 on every pop, including wen=0 entries, and wraps modulo 2^64.
- Reset mid-operation: all buffered entries are dropped and no write is issued after the reset edge.

Test Plan:
1. NSRC=2. Push in_wen=2'b11, rd=5, src0=0x11, src1=0x22; hold=0 -> one cycle later out_valid=1, out_wen=1, out_waddr=5, out_wdata=0x11; commit_cnt=1.
2. Push in_wen=2'b10, rd=0, src1=0xAB -> out_valid=1, out_wen=0, out_wdata=0, commit_cnt increments. Then push in_wen=0, rd=7 -> same retire with out_wen=0.
3. DEPTH=2, wb_hold=1, push 3 back-to-back requests -> first two accepted and in_ready=0 on the third (fifo_cnt=2). Drop hold -> the two writes issue in order on consecutive cycles, then the third is accepted.
4. Continuous push every cycle with hold=0 for 10 requests -> 10 consecutive out_valid pulses in order, pointers wrap, fifo_cnt stays at or below 1, commit_cnt=10.
5. Two entries buffered, assert flush for one cycle -> no out_valid afterwards, fifo_cnt=0, commit_cnt unchanged. A push in the flush cycle is refused because in_ready=0.
6. Assert rst with two entries buffered and commit_cnt=4 -> after the edge all outputs are 0 and commit_cnt=0. No write is issued and in_ready=1 the cycle after rst drops.
